// File: rtl/reg_ctx_engine.sv
// reg_ctx_engine: moves a register context (R0..R7 plus an optional status
// word) between a register file and a pair of valid/ready word streams.
//   save    (mode=0): regfile/psr_in -> out_valid/out_ready/out_data
//   restore (mode=1): in_valid/in_ready/in_data -> regfile / status register
// Ports:
//   clk, reset              rising-edge clock, synchronous active-high reset
//   start, mode             transfer request and direction, sampled in IDLE
//   busy, done              transfer in progress, one-cycle completion pulse
//   rf_sel / rf_rdata       regfile sr1 select and read data
//   rf_dr, rf_ld, rf_wdata,
//   rf_bus_en               regfile write port (destination, load, data, gate)
//   psr_in                  current status register value
//   sr_ld_ext, sr_d_ext     status register external load strobe and data
//   out_valid/ready/data    save stream
//   in_valid/ready/data     restore stream
// All outputs are registered; each is computed from the next state and index.
module reg_ctx_engine #(
  parameter int unsigned INCLUDE_PSR = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        mode,
  output logic        busy,
  output logic        done,
  output logic [2:0]  rf_sel,
  input  logic [15:0] rf_rdata,
  output logic [2:0]  rf_dr,
  output logic        rf_ld,
  output logic [15:0] rf_wdata,
  output logic        rf_bus_en,
  input  logic [15:0] psr_in,
  output logic        sr_ld_ext,
  output logic [15:0] sr_d_ext,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] out_data,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [15:0] in_data
);

  localparam int unsigned DW = 16;
  localparam int unsigned IW = 4;
  localparam int unsigned RW = 3;

  // Index of the final word: the status word sits at index 8 when present.
  localparam logic [IW-1:0] LAST_IDX = (INCLUDE_PSR != 0) ? IW'(8) : IW'(7);

  localparam logic [2:0] IDLE    = 3'd0;
  localparam logic [2:0] S_FETCH = 3'd1;
  localparam logic [2:0] S_SEND  = 3'd2;
  localparam logic [2:0] R_RECV  = 3'd3;
  localparam logic [2:0] R_WRITE = 3'd4;
  localparam logic [2:0] DONE    = 3'd5;

  logic [2:0]    r_state;
  logic [IW-1:0] r_idx;
  logic [DW-1:0] r_wreg;

  logic          r_busy;
  logic          r_done;
  logic [RW-1:0] r_rf_sel;
  logic [RW-1:0] r_rf_dr;
  logic          r_rf_ld;
  logic [DW-1:0] r_rf_wdata;
  logic          r_rf_bus_en;
  logic          r_sr_ld_ext;
  logic [DW-1:0] r_sr_d_ext;
  logic          r_out_valid;
  logic [DW-1:0] r_out_data;
  logic          r_in_ready;

  logic [2:0]    w_state_nxt;
  logic [IW-1:0] w_idx_nxt;
  logic [DW-1:0] w_wreg_nxt;
  logic [DW-1:0] w_out_data_nxt;
  logic          w_at_last;

  logic          w_busy_nxt;
  logic          w_done_nxt;
  logic [RW-1:0] w_rf_sel_nxt;
  logic [RW-1:0] w_rf_dr_nxt;
  logic          w_rf_ld_nxt;
  logic [DW-1:0] w_rf_wdata_nxt;
  logic          w_rf_bus_en_nxt;
  logic          w_sr_ld_ext_nxt;
  logic [DW-1:0] w_sr_d_ext_nxt;
  logic          w_out_valid_nxt;
  logic          w_in_ready_nxt;
  logic          w_is_write;

  assign w_at_last = (r_idx >= LAST_IDX);

  // Next-state, index and data-register logic.
  always_comb begin
    w_state_nxt    = r_state;
    w_idx_nxt      = r_idx;
    w_wreg_nxt     = r_wreg;
    w_out_data_nxt = r_out_data;
    case (r_state)
      IDLE: begin
        w_idx_nxt = '0;
        if (start) begin
          w_state_nxt = mode ? R_RECV : S_FETCH;
        end
      end
      S_FETCH: begin
        // rf_sel already presents idx[2:0] this cycle, so rf_rdata is valid.
        w_out_data_nxt = r_idx[3] ? psr_in : rf_rdata;
        w_state_nxt    = S_SEND;
      end
      S_SEND: begin
        if (out_ready) begin
          if (w_at_last) begin
            w_state_nxt = DONE;
          end else begin
            w_idx_nxt   = r_idx + IW'(1);
            w_state_nxt = S_FETCH;
          end
        end
      end
      R_RECV: begin
        if (in_valid) begin
          w_wreg_nxt  = in_data;
          w_state_nxt = R_WRITE;
        end
      end
      R_WRITE: begin
        if (w_at_last) begin
          w_state_nxt = DONE;
        end else begin
          w_idx_nxt   = r_idx + IW'(1);
          w_state_nxt = R_RECV;
        end
      end
      DONE: begin
        w_idx_nxt   = '0;
        w_state_nxt = IDLE;
      end
      default: begin
        w_idx_nxt   = '0;
        w_state_nxt = IDLE;
      end
    endcase
  end

  // Output values for the coming cycle, derived from the next state/index.
  always_comb begin
    w_busy_nxt      = 1'b0;
    w_done_nxt      = 1'b0;
    w_rf_sel_nxt    = '0;
    w_rf_dr_nxt     = '0;
    w_rf_ld_nxt     = 1'b0;
    w_rf_wdata_nxt  = '0;
    w_rf_bus_en_nxt = 1'b0;
    w_sr_ld_ext_nxt = 1'b0;
    w_sr_d_ext_nxt  = '0;
    w_out_valid_nxt = 1'b0;
    w_in_ready_nxt  = 1'b0;
    w_is_write      = (w_state_nxt == R_WRITE);

    w_busy_nxt      = (w_state_nxt != IDLE);
    w_done_nxt      = (w_state_nxt == DONE);
    w_out_valid_nxt = (w_state_nxt == S_SEND);
    w_in_ready_nxt  = (w_state_nxt == R_RECV);

    if ((w_state_nxt == S_FETCH) || (w_state_nxt == S_SEND)) begin
      w_rf_sel_nxt = w_idx_nxt[RW-1:0];
    end

    // Word 8 goes to the status register; words 0..7 go to the regfile.
    if (w_is_write && !w_idx_nxt[3]) begin
      w_rf_ld_nxt     = 1'b1;
      w_rf_bus_en_nxt = 1'b1;
      w_rf_dr_nxt     = w_idx_nxt[RW-1:0];
      w_rf_wdata_nxt  = w_wreg_nxt;
    end
    if (w_is_write && w_idx_nxt[3]) begin
      w_sr_ld_ext_nxt = 1'b1;
      w_sr_d_ext_nxt  = w_wreg_nxt;
    end
  end

  // State, datapath and output registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= IDLE;
      r_idx       <= '0;
      r_wreg      <= '0;
      r_out_data  <= '0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_rf_sel    <= '0;
      r_rf_dr     <= '0;
      r_rf_ld     <= 1'b0;
      r_rf_wdata  <= '0;
      r_rf_bus_en <= 1'b0;
      r_sr_ld_ext <= 1'b0;
      r_sr_d_ext  <= '0;
      r_out_valid <= 1'b0;
      r_in_ready  <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_idx       <= w_idx_nxt;
      r_wreg      <= w_wreg_nxt;
      r_out_data  <= w_out_data_nxt;
      r_busy      <= w_busy_nxt;
      r_done      <= w_done_nxt;
      r_rf_sel    <= w_rf_sel_nxt;
      r_rf_dr     <= w_rf_dr_nxt;
      r_rf_ld     <= w_rf_ld_nxt;
      r_rf_wdata  <= w_rf_wdata_nxt;
      r_rf_bus_en <= w_rf_bus_en_nxt;
      r_sr_ld_ext <= w_sr_ld_ext_nxt;
      r_sr_d_ext  <= w_sr_d_ext_nxt;
      r_out_valid <= w_out_valid_nxt;
      r_in_ready  <= w_in_ready_nxt;
    end
  end

  assign busy      = r_busy;
  assign done      = r_done;
  assign rf_sel    = r_rf_sel;
  assign rf_dr     = r_rf_dr;
  assign rf_ld     = r_rf_ld;
  assign rf_wdata  = r_rf_wdata;
  assign rf_bus_en = r_rf_bus_en;
  assign sr_ld_ext = r_sr_ld_ext;
  assign sr_d_ext  = r_sr_d_ext;
  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign in_ready  = r_in_ready;

endmodule

// File: tb/tb_reg_ctx_engine.sv
// Bench for reg_ctx_engine: one instance with the status word, one without,
// sharing a regfile/PSR model. A negedge monitor checks the active instance
// against transaction-level expectations (expected beats, expected writes).
module tb_reg_ctx_engine;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset, start, mode, sel, out_ready, in_valid;
  logic [15:0] in_data;
  logic        start0, start1;
  assign start0 = start & ~sel;
  assign start1 = start & sel;

  logic [15:0] regs [8];
  logic [15:0] psr_reg;
  logic        pl_en;
  logic [15:0] pl_vals [8];
  logic [15:0] pl_psr;

  logic        busy0, done0, rf_ld0, rf_bus_en0, sr_ld_ext0, out_valid0, in_ready0;
  logic [2:0]  rf_sel0, rf_dr0;
  logic [15:0] rf_rdata0, rf_wdata0, sr_d_ext0, out_data0;
  logic        busy1, done1, rf_ld1, rf_bus_en1, sr_ld_ext1, out_valid1, in_ready1;
  logic [2:0]  rf_sel1, rf_dr1;
  logic [15:0] rf_rdata1, rf_wdata1, sr_d_ext1, out_data1;

  assign rf_rdata0 = regs[rf_sel0];
  assign rf_rdata1 = regs[rf_sel1];

  reg_ctx_engine #(.INCLUDE_PSR(0)) u_dut0 (
    .clk(clk), .reset(reset), .start(start0), .mode(mode),
    .busy(busy0), .done(done0), .rf_sel(rf_sel0), .rf_rdata(rf_rdata0),
    .rf_dr(rf_dr0), .rf_ld(rf_ld0), .rf_wdata(rf_wdata0), .rf_bus_en(rf_bus_en0),
    .psr_in(psr_reg), .sr_ld_ext(sr_ld_ext0), .sr_d_ext(sr_d_ext0),
    .out_valid(out_valid0), .out_ready(out_ready), .out_data(out_data0),
    .in_valid(in_valid), .in_ready(in_ready0), .in_data(in_data));

  reg_ctx_engine #(.INCLUDE_PSR(1)) u_dut1 (
    .clk(clk), .reset(reset), .start(start1), .mode(mode),
    .busy(busy1), .done(done1), .rf_sel(rf_sel1), .rf_rdata(rf_rdata1),
    .rf_dr(rf_dr1), .rf_ld(rf_ld1), .rf_wdata(rf_wdata1), .rf_bus_en(rf_bus_en1),
    .psr_in(psr_reg), .sr_ld_ext(sr_ld_ext1), .sr_d_ext(sr_d_ext1),
    .out_valid(out_valid1), .out_ready(out_ready), .out_data(out_data1),
    .in_valid(in_valid), .in_ready(in_ready1), .in_data(in_data));

  // View of the selected instance.
  logic        v_busy, v_done, v_rf_ld, v_rf_bus_en, v_sr_ld_ext, v_out_valid, v_in_ready;
  logic [2:0]  v_rf_sel, v_rf_dr;
  logic [15:0] v_rf_wdata, v_sr_d_ext, v_out_data;
  assign v_busy      = sel ? busy1      : busy0;
  assign v_done      = sel ? done1      : done0;
  assign v_rf_ld     = sel ? rf_ld1     : rf_ld0;
  assign v_rf_bus_en = sel ? rf_bus_en1 : rf_bus_en0;
  assign v_sr_ld_ext = sel ? sr_ld_ext1 : sr_ld_ext0;
  assign v_out_valid = sel ? out_valid1 : out_valid0;
  assign v_in_ready  = sel ? in_ready1  : in_ready0;
  assign v_rf_sel    = sel ? rf_sel1    : rf_sel0;
  assign v_rf_dr     = sel ? rf_dr1     : rf_dr0;
  assign v_rf_wdata  = sel ? rf_wdata1  : rf_wdata0;
  assign v_sr_d_ext  = sel ? sr_d_ext1  : sr_d_ext0;
  assign v_out_data  = sel ? out_data1  : out_data0;

  // Regfile and status register model, written by the selected instance.
  always @(posedge clk) begin
    if (pl_en) begin
      for (int i = 0; i < 8; i++) regs[i] <= pl_vals[i];
      psr_reg <= pl_psr;
    end else begin
      if (v_rf_ld && v_rf_bus_en) regs[v_rf_dr] <= v_rf_wdata;
      if (v_sr_ld_ext) psr_reg <= v_sr_d_ext;
    end
  end

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  // Transaction-level expectations.
  logic [15:0] exp_beats [$];
  logic [15:0] got_beats [$];
  logic [18:0] exp_wr [$];
  logic [15:0] exp_sr [$];
  bit          mon_en = 1'b0;
  bit          fast = 1'b0;
  int          done_cnt = 0;
  int          cyc = 0;
  int          beat_n = 0;
  bit          prev_busy = 1'b0;
  bit          prev_stall = 1'b0;
  logic [15:0] prev_data = '0;
  bit          in_hs = 1'b0;

  always @(negedge clk) begin
    int last;
    logic [15:0] e16;
    logic [18:0] e19;
    last = sel ? 8 : 7;
    if (mon_en) begin
      cyc = v_busy ? (prev_busy ? cyc + 1 : 1) : 0;
      if (prev_stall) begin
        chk("hold_valid", 32'(v_out_valid), 1);
        chk("hold_data", 32'(v_out_data), 32'(prev_data));
      end
      if (v_out_valid) chk("save_rf_sel", 32'(v_rf_sel), 32'(beat_n % 8));
      if (v_out_valid && out_ready) begin
        chk("beat_expected", 32'(exp_beats.size() > 0), 1);
        if (exp_beats.size() > 0) begin
          e16 = exp_beats.pop_front();
          chk("beat_data", 32'(v_out_data), 32'(e16));
        end
        got_beats.push_back(v_out_data);
        beat_n++;
      end
      if (v_rf_ld) begin
        chk("rf_ld_expected", 32'(exp_wr.size() > 0), 1);
        chk("rf_bus_en", 32'(v_rf_bus_en), 1);
        if (exp_wr.size() > 0) begin
          e19 = exp_wr.pop_front();
          chk("rf_write", 32'({v_rf_dr, v_rf_wdata}), 32'(e19));
        end
      end
      if (v_sr_ld_ext) begin
        chk("sr_ld_expected", 32'(exp_sr.size() > 0), 1);
        chk("sr_no_rf_ld", 32'(v_rf_ld), 0);
        if (exp_sr.size() > 0) begin
          e16 = exp_sr.pop_front();
          chk("sr_write", 32'(v_sr_d_ext), 32'(e16));
        end
      end
      if (!v_busy) begin
        chk("idle_outputs", 32'({v_out_valid, v_in_ready, v_rf_ld, v_rf_bus_en,
                                 v_sr_ld_ext, v_done, v_rf_sel}), 0);
        beat_n = 0;
      end
      if (v_done) begin
        done_cnt++;
        chk("done_busy", 32'(v_busy), 1);
        if (fast) chk("done_cycle", 32'(cyc), 32'(2 * (last + 1) + 1));
        else      chk("done_min_cycle", 32'(cyc >= 2 * (last + 1) + 1), 1);
      end
      prev_stall = v_out_valid && !out_ready && !reset;
      prev_data  = v_out_data;
      prev_busy  = v_busy;
      in_hs      = v_in_ready && in_valid;
    end
  end

  task automatic preload(input logic [15:0] base, input logic [15:0] p, input bit rnd);
    for (int i = 0; i < 8; i++) pl_vals[i] = rnd ? 16'($urandom) : base + 16'(i);
    pl_psr = p;
    pl_en  = 1'b1;
    @(posedge clk); #1;
    pl_en  = 1'b0;
  endtask

  task automatic run_save(input bit bp, input bit poke);
    int n, d0, last;
    last = sel ? 8 : 7;
    exp_beats.delete();
    got_beats.delete();
    for (int k = 0; k <= last; k++) exp_beats.push_back(k < 8 ? regs[k] : psr_reg);
    fast = !bp;
    d0 = done_cnt;
    mode = 1'b0; start = 1'b1;
    out_ready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    n = 0;
    while (done_cnt == d0 && n < 400) begin
      out_ready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
      if (poke) begin
        mode  = 1'($urandom_range(0, 1));
        start = (n == 4) || (n == 9);
      end
      @(posedge clk); #1;
      n++;
    end
    start = 1'b0; mode = 1'b0;
    chk("save_timeout", 32'(done_cnt != d0), 1);
    repeat (3) @(posedge clk);
    #1;
    chk("save_one_done", 32'(done_cnt - d0), 1);
    chk("save_beats_left", 32'(exp_beats.size()), 0);
    chk("save_idle", 32'(v_busy), 0);
  endtask

  task automatic run_restore(input bit bp, input int reset_at, input bit directed);
    int n, d0, last, wi;
    bit aborted;
    logic [15:0] w [9];
    logic [15:0] old_regs [8];
    logic [15:0] old_psr;
    last = sel ? 8 : 7;
    for (int k = 0; k < 9; k++)
      w[k] = directed ? ((k < 8) ? 16'hA000 + 16'(k) : 16'h0004) : 16'($urandom);
    for (int k = 0; k < 8; k++) old_regs[k] = regs[k];
    old_psr = psr_reg;
    exp_wr.delete();
    exp_sr.delete();
    for (int k = 0; k <= last; k++) begin
      if (k < 8) exp_wr.push_back({3'(k), w[k]});
      else       exp_sr.push_back(w[k]);
    end
    fast = !bp;
    d0 = done_cnt;
    wi = 0;
    aborted = 1'b0;
    mode = 1'b1; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    n = 0;
    while (done_cnt == d0 && n < 400 && !aborted) begin
      in_valid = bp ? 1'($urandom_range(0, 1)) : 1'b1;
      in_data  = (wi <= last) ? w[wi] : 16'($urandom);
      start    = (n == 5);
      mode     = (n == 5) ? 1'b0 : 1'b1;
      @(posedge clk); #1;
      n++;
      if (in_hs) wi++;
      if (reset_at >= 0 && v_rf_ld && 32'(v_rf_dr) == 32'(reset_at)) begin
        start = 1'b0; reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        aborted = 1'b1;
        exp_wr.delete();
        exp_sr.delete();
        chk("rst_ctl", 32'({v_busy, v_done, v_out_valid, v_in_ready, v_rf_ld,
                            v_rf_bus_en, v_sr_ld_ext}), 0);
        chk("rst_sel_dr", 32'({v_rf_sel, v_rf_dr}), 0);
        chk("rst_rf_wdata", 32'(v_rf_wdata), 0);
        chk("rst_sr_d", 32'(v_sr_d_ext), 0);
        chk("rst_out_data", 32'(v_out_data), 0);
        chk("rst_last_write", 32'(regs[reset_at]), 32'(w[reset_at]));
        for (int k = reset_at + 1; k < 8; k++)
          chk("rst_untouched", 32'(regs[k]), 32'(old_regs[k]));
        chk("rst_psr", 32'(psr_reg), 32'(old_psr));
      end
    end
    start = 1'b0; mode = 1'b0; in_valid = 1'b0;
    if (!aborted) chk("restore_timeout", 32'(done_cnt != d0), 1);
    repeat (3) @(posedge clk);
    #1;
    chk("restore_done_cnt", 32'(done_cnt - d0), aborted ? 0 : 1);
    chk("restore_left", 32'(exp_wr.size() + exp_sr.size()), 0);
    chk("restore_idle", 32'(v_busy), 0);
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; mode = 1'b0; sel = 1'b1;
    out_ready = 1'b0; in_valid = 1'b0; in_data = '0;
    pl_en = 1'b0; pl_psr = '0;
    for (int i = 0; i < 8; i++) pl_vals[i] = '0;
    @(posedge clk); #1;
    start = 1'b1;
    @(posedge clk); #1;
    chk("rst_ctl1", 32'({busy1, done1, out_valid1, in_ready1, rf_ld1, rf_bus_en1, sr_ld_ext1}), 0);
    chk("rst_data1", 32'({out_data1, rf_wdata1}), 0);
    chk("rst_misc1", 32'({sr_d_ext1, rf_sel1, rf_dr1}), 0);
    chk("rst_ctl0", 32'({busy0, done0, out_valid0, in_ready0, rf_ld0, rf_bus_en0, sr_ld_ext0}), 0);
    chk("rst_data0", 32'({out_data0, rf_wdata0}), 0);
    start = 1'b0;
    reset = 1'b0;
    mon_en = 1'b1;

    // Directed save with status word.
    preload(16'h1000, 16'h8002, 1'b0);
    run_save(1'b0, 1'b0);
    chk("sv_count", 32'(got_beats.size()), 9);
    if (got_beats.size() == 9) begin
      chk("sv_first", 32'(got_beats[0]), 32'h1000);
      chk("sv_r5", 32'(got_beats[5]), 32'h1005);
      chk("sv_psr", 32'(got_beats[8]), 32'h8002);
    end

    // Directed restore with status word.
    run_restore(1'b0, -1, 1'b1);
    chk("rs_r0", 32'(regs[0]), 32'hA000);
    chk("rs_r7", 32'(regs[7]), 32'hA007);
    chk("rs_psr", 32'(psr_reg), 32'h0004);

    // Backpressure and start/mode activity while busy.
    preload(16'h0, 16'($urandom), 1'b1);
    repeat (4) run_save(1'b1, 1'b0);
    run_save(1'b0, 1'b1);
    run_save(1'b1, 1'b1);

    // Reset after the third restored word, then a clean restore.
    preload(16'h0, 16'h5A5A, 1'b1);
    run_restore(1'b0, 2, 1'b0);
    run_restore(1'b0, -1, 1'b0);
    run_restore(1'b1, -1, 1'b0);

    // Instance without the status word.
    sel = 1'b0;
    preload(16'h1000, 16'h8002, 1'b0);
    run_save(1'b0, 1'b0);
    chk("sv0_count", 32'(got_beats.size()), 8);
    if (got_beats.size() == 8) chk("sv0_last", 32'(got_beats[7]), 32'h1007);
    run_restore(1'b0, -1, 1'b1);
    chk("rs0_r7", 32'(regs[7]), 32'hA007);
    chk("rs0_psr_kept", 32'(psr_reg), 32'h8002);
    run_restore(1'b1, -1, 1'b0);
    run_save(1'b1, 1'b1);

    // Random mix across both instances.
    for (int t = 0; t < 10; t++) begin
      sel = 1'($urandom_range(0, 1));
      preload(16'h0, 16'($urandom), 1'b1);
      if ($urandom_range(0, 1) == 1) run_save(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      else run_restore(1'($urandom_range(0, 1)), -1, 1'b0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
